dshift_feeder: RTL

Upstream sequencer for the `dshift` operand shift register that feeds the EKF-SLAM systolic array. On a start pulse it streams a contiguous run of matrix elements out of a synchronous block RAM with fixed read latency. It then drives each returned element onto the `dshift` `din`/`dir` pair, with the direction code aligned to the data. It reports completion with a one-cycle done pulse, so the matrix-op controller can chain bursts back to back.

---
 rtl/dshift_feeder_pkg.sv | 19 +
 rtl/dshift_feeder_if.sv | 14 +
 rtl/dshift_feeder_feed_pipe.sv | 47 ++++
 rtl/dshift_feeder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/dshift_feeder_pkg.sv
// rtl/dshift_feeder_pkg.sv - shared direction codes and FSM encoding for dshift_feeder
// Contents: dir_e (dshift direction codes, shared with dshift), state_e (burst FSM states).
package dshift_feeder_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE  = 2'b00,
        DIR_POS   = 2'b01,
        DIR_NEW_0 = 2'b10,
        DIR_NEW_1 = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10,
        FIN   = 2'b11
    } state_e;

endpackage

// File: rtl/dshift_feeder_if.sv
// rtl/dshift_feeder_if.sv - synchronous block RAM read port between feeder and RAM
// Signals: ram_en (read enable), ram_addr (read address), ram_dout (data, fixed latency).
// Modports: master (feeder side), slave (RAM side).
interface dshift_feeder_if #(
    parameter int DW = 16,
    parameter int AW = 10
) ();
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;

    modport master (output ram_en, output ram_addr, input ram_dout);
    modport slave  (input ram_en, input ram_addr, output ram_dout);
endinterface

// File: rtl/dshift_feeder_feed_pipe.sv
// rtl/dshift_feeder_feed_pipe.sv - RD_LAT-deep {valid, mode} delay line beside RAM reads
// Ports: clk, rst_n (async active-low clear), in_valid/in_mode (read issued this cycle),
//        out_valid/out_mode (tag aligned with the RAM data returning this cycle).
module feed_pipe
    import dshift_feeder_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] in_mode,
    output logic       out_valid,
    output logic [1:0] out_mode
);

    logic [RD_LAT-1:0]       vld_q, vld_d;
    logic [RD_LAT-1:0][1:0]  mode_q, mode_d;

    always_comb begin
        vld_d  = vld_q;
        mode_d = mode_q;
        vld_d[0]  = in_valid;
        // Empty slots carry IDLE so a stale mode can never leak downstream.
        mode_d[0] = in_valid ? in_mode : DIR_IDLE;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            mode_d[i] = mode_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                mode_q[i] <= DIR_IDLE;
            end
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_mode  = mode_q[RD_LAT-1];

endmodule

// File: rtl/dshift_feeder.sv
// rtl/dshift_feeder.sv - burst reader from block RAM feeding the dshift din/dir pair
// Ports: clk, sys_rst_n (async active-low), start/mode/base_addr/len (burst request),
//        busy/done (status), ram (RAM read port, master), dir/din (registered to dshift).
module dshift_feeder
    import dshift_feeder_pkg::*;
#(
    parameter int DW     = 16,
    parameter int AW     = 10,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                sys_rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW-1:0]       len,
    output logic                busy,
    output logic                done,
    dshift_feeder_if.master     ram,
    output logic [1:0]          dir,
    output logic [DW-1:0]       din
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] len_q, len_d;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    dir_q, dir_d;
    logic [DW-1:0] din_q, din_d;

    logic          pipe_vld;
    logic [1:0]    pipe_mode;

    // cnt_q counts reads in ISSUE and then the fixed drain wait in DRAIN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start) begin
                    mode_d  = mode;
                    len_d   = len;
                    addr_d  = base_addr;
                    cnt_d   = '0;
                    state_d = (len != '0) ? ISSUE : DRAIN;
                end
            end
            ISSUE: begin
                addr_d = addr_q + AW'(1);
                if (cnt_q == len_q - AW'(1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            DRAIN: begin
                // RD_LAT+1 cycles: RAM latency plus the output register.
                if (cnt_q == AW'(RD_LAT)) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dir_d = DIR_IDLE;
        din_d = '0;
        if (pipe_vld) begin
            dir_d = pipe_mode;
            din_d = ram.ram_dout;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            mode_q  <= DIR_IDLE;
            dir_q   <= DIR_IDLE;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            din_q   <= din_d;
        end
    end

    feed_pipe #(
        .RD_LAT (RD_LAT)
    ) u_feed_pipe (
        .clk       (clk),
        .rst_n     (sys_rst_n),
        .in_valid  (ram.ram_en),
        .in_mode   (mode_q),
        .out_valid (pipe_vld),
        .out_mode  (pipe_mode)
    );

    assign ram.ram_en   = (state_q == ISSUE);
    assign ram.ram_addr = addr_q;
    assign busy         = (state_q == ISSUE) || (state_q == DRAIN);
    assign done         = (state_q == FIN);
    assign dir          = dir_q;
    assign din          = din_q;

endmodule
